// File: rtl/instr_word_encoder.sv
// Packs instruction fields into 16-bit words and buffers them in a small FIFO.
// Optional INSTR_ENC_STATS_EN adds an emitted-word counter and sticky overflow flag.
module instr_word_encoder #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 4,
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_opcode,
  input  logic                 in_imm_flag,
  input  logic [2:0]           in_reg,
  input  logic [2:0]           in_dest,
  input  logic [2:0]           in_src,
  input  logic [7:0]           in_imm8,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_word,
  output logic                 out_imm_flag,
  output logic [PTR_W:0]       level
`ifdef INSTR_ENC_STATS_EN
  ,
  output logic [15:0]          words_emitted,
  output logic                 fifo_overflow_attempt
`endif
);

  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic                 flag;
    logic [WORD_SIZE-1:0] word;
  } ent_t;

  ent_t             mem [DEPTH];
  ent_t             enc;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  always_comb begin
    enc.flag = in_imm_flag;
    if (in_imm_flag) begin
      enc.word = {in_opcode, in_reg, in_imm8};
    end else begin
      enc.word = {in_opcode, 3'b000, 1'b0, in_dest, 1'b0, in_src};
    end
  end

  assign full      = (level == FULL_LVL);
  assign empty     = (level == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head is masked while empty so stale storage never reaches the consumer.
  assign out_word     = empty ? '0   : mem[rd_ptr].word;
  assign out_imm_flag = empty ? 1'b0 : mem[rd_ptr].flag;

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= enc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        level <= level - (PTR_W+1)'(1);
      end
    end
  end

`ifdef INSTR_ENC_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      words_emitted         <= '0;
      fifo_overflow_attempt <= 1'b0;
    end else begin
      if (pop) begin
        words_emitted <= words_emitted + 16'd1;
      end
      if (in_valid && full) begin
        fifo_overflow_attempt <= 1'b1;
      end
    end
  end
`endif

endmodule
